// File: rtl/fpga_test_pkg.sv
// fpga_test_pkg: shared frame-state type, default sizes and saturating-increment helper.
// Used by fpga_xor_checksum (optional beat counter under XOR_CHK_COUNT_EN).
`default_nettype none

package fpga_test_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_CHANNELS = 2;
  localparam int DEF_CNT_W    = 16;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } frame_state_t;

  // Saturating increment for a counter of width w (1..32), carried in a 32-bit value.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned w);
    logic [31:0] max_val;
    max_val = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (val >= max_val) ? max_val : (val + 32'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fpga_xor_checksum_xor_reduce.sv
// xor_reduce: combinational XOR of CHANNELS words of WIDTH bits packed into one bus.
// Channel k lives at bits [k*WIDTH +: WIDTH]; with one channel the word passes through.
`default_nettype none

module xor_reduce #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2
) (
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [WIDTH-1:0]          beat_xor
);

  always_comb begin
    beat_xor = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      beat_xor = beat_xor ^ in_data[k*WIDTH +: WIDTH];
    end
  end

endmodule

`default_nettype wire

// File: rtl/fpga_xor_checksum.sv
// fpga_xor_checksum: registered per-beat XOR fold plus running frame checksum, valid/ready on both sides.
// Define XOR_CHK_COUNT_EN to add the saturating frame beat counter and the out_beats port.
`default_nettype none

module fpga_xor_checksum
  import fpga_test_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic                      in_valid,
  input  logic                      in_last,
  output logic                      in_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_last,
  output logic [WIDTH-1:0]          out_chk
`ifdef XOR_CHK_COUNT_EN
  ,
  output logic [CNT_W-1:0]          out_beats
`endif
);

  frame_state_t     state, state_nxt;
  logic [WIDTH-1:0] beat_xor;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] chk_nxt;
  logic             accept;

  xor_reduce #(
    .WIDTH   (WIDTH),
    .CHANNELS(CHANNELS)
  ) u_xor_reduce (
    .in_data (in_data),
    .beat_xor(beat_xor)
  );

  // The output register can take a new beat whenever it is empty or being drained.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_nxt = state;
    chk_nxt   = ((state == IDLE) ? '0 : acc) ^ beat_xor;
    case (state)
      IDLE:    if (accept && !in_last) state_nxt = FRAME;
      FRAME:   if (accept && in_last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_chk   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        acc       <= chk_nxt;
        out_valid <= 1'b1;
        out_data  <= beat_xor;
        out_last  <= in_last;
        out_chk   <= chk_nxt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef XOR_CHK_COUNT_EN
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = (state == IDLE) ? CNT_W'(1) : CNT_W'(sat_inc(32'(cnt), CNT_W));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      out_beats <= '0;
    end else if (accept) begin
      cnt       <= cnt_nxt;
      out_beats <= cnt_nxt;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fpga_xor_checksum.sv
// tb_fpga_xor_checksum: directed vectors against three configurations of fpga_xor_checksum.
`default_nettype none
`timescale 1ns/1ps

module tb_fpga_xor_checksum;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // DUT A: WIDTH=8, CHANNELS=2, CNT_W=16
  logic [15:0] in_data_a  = '0;
  logic        in_valid_a = 1'b0, in_last_a = 1'b0, out_ready_a = 1'b1;
  logic        in_ready_a, out_valid_a, out_last_a;
  logic [7:0]  out_data_a, out_chk_a;
`ifdef XOR_CHK_COUNT_EN
  logic [15:0] out_beats_a;
`endif

  fpga_xor_checksum #(.WIDTH(8), .CHANNELS(2), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst),
    .in_data(in_data_a), .in_valid(in_valid_a), .in_last(in_last_a), .in_ready(in_ready_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_data(out_data_a), .out_last(out_last_a), .out_chk(out_chk_a)
`ifdef XOR_CHK_COUNT_EN
    , .out_beats(out_beats_a)
`endif
  );

  // DUT B: CHANNELS=4, CNT_W=2
  logic [31:0] in_data_b  = '0;
  logic        in_valid_b = 1'b0, in_last_b = 1'b0, out_ready_b = 1'b1;
  logic        in_ready_b, out_valid_b, out_last_b;
  logic [7:0]  out_data_b, out_chk_b;
`ifdef XOR_CHK_COUNT_EN
  logic [1:0]  out_beats_b;
`endif

  fpga_xor_checksum #(.WIDTH(8), .CHANNELS(4), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst),
    .in_data(in_data_b), .in_valid(in_valid_b), .in_last(in_last_b), .in_ready(in_ready_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_data(out_data_b), .out_last(out_last_b), .out_chk(out_chk_b)
`ifdef XOR_CHK_COUNT_EN
    , .out_beats(out_beats_b)
`endif
  );

  // DUT C: CHANNELS=1
  logic [7:0]  in_data_c  = '0;
  logic        in_valid_c = 1'b0, in_last_c = 1'b0, out_ready_c = 1'b1;
  logic        in_ready_c, out_valid_c, out_last_c;
  logic [7:0]  out_data_c, out_chk_c;
`ifdef XOR_CHK_COUNT_EN
  logic [15:0] out_beats_c;
`endif

  fpga_xor_checksum #(.WIDTH(8), .CHANNELS(1), .CNT_W(16)) dut_c (
    .clk(clk), .rst(rst),
    .in_data(in_data_c), .in_valid(in_valid_c), .in_last(in_last_c), .in_ready(in_ready_c),
    .out_valid(out_valid_c), .out_ready(out_ready_c),
    .out_data(out_data_c), .out_last(out_last_c), .out_chk(out_chk_c)
`ifdef XOR_CHK_COUNT_EN
    , .out_beats(out_beats_c)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one beat to DUT A, wait for acceptance edge, check the registered result.
  task automatic beat_a(input string tag, input logic [7:0] c1, input logic [7:0] c0,
                        input logic last, input logic [7:0] exp_data,
                        input logic [7:0] exp_chk, input logic [15:0] exp_beats);
    in_data_a  = {c1, c0};
    in_last_a  = last;
    in_valid_a = 1'b1;
    #1;
    check_eq({tag, " in_ready"}, 32'(in_ready_a), 32'd1);
    @(posedge clk); #1;
    check_eq({tag, " valid"}, 32'(out_valid_a), 32'd1);
    check_eq({tag, " data"},  32'(out_data_a),  32'(exp_data));
    check_eq({tag, " chk"},   32'(out_chk_a),   32'(exp_chk));
    check_eq({tag, " last"},  32'(out_last_a),  32'(last));
`ifdef XOR_CHK_COUNT_EN
    check_eq({tag, " beats"}, 32'(out_beats_a), 32'(exp_beats));
`else
    if (exp_beats == 16'hFFFF) n_checks += 0;
`endif
  endtask

  task automatic idle_a();
    in_valid_a = 1'b0;
    in_last_a  = 1'b0;
    @(posedge clk); #1;
  endtask

  logic [7:0] exp_chk_b   [5] = '{8'h0F, 8'h00, 8'h0F, 8'h00, 8'h0F};
  logic [1:0] exp_beats_b [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset valid", 32'(out_valid_a), 32'd0);
    check_eq("reset data",  32'(out_data_a),  32'd0);
    check_eq("reset chk",   32'(out_chk_a),   32'd0);
    check_eq("reset last",  32'(out_last_a),  32'd0);
`ifdef XOR_CHK_COUNT_EN
    check_eq("reset beats", 32'(out_beats_a), 32'd0);
`endif
    rst = 1'b0;
    #1;
    check_eq("reset in_ready", 32'(in_ready_a), 32'd1);

    beat_a("single", 8'hF0, 8'h0F, 1'b1, 8'hFF, 8'hFF, 16'd1);
    beat_a("f1b1", 8'h12, 8'h34, 1'b0, 8'h26, 8'h26, 16'd1);
    beat_a("f1b2", 8'hAA, 8'h55, 1'b0, 8'hFF, 8'hD9, 16'd2);
    beat_a("f1b3", 8'h01, 8'h01, 1'b1, 8'h00, 8'hD9, 16'd3);
    idle_a();
    check_eq("drain valid", 32'(out_valid_a), 32'd0);
    check_eq("drain hold data", 32'(out_data_a), 32'h00);
    check_eq("drain hold chk",  32'(out_chk_a),  32'hD9);

    // Backpressure mid-frame: held beat must stay frozen while the next waits.
    out_ready_a = 1'b0;
    beat_a("bp b1", 8'h12, 8'h34, 1'b0, 8'h26, 8'h26, 16'd1);
    in_data_a  = {8'hAA, 8'h55};
    in_last_a  = 1'b0;
    in_valid_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("bp in_ready", 32'(in_ready_a), 32'd0);
      check_eq("bp valid",    32'(out_valid_a), 32'd1);
      check_eq("bp data",     32'(out_data_a),  32'h26);
      check_eq("bp chk",      32'(out_chk_a),   32'h26);
      @(posedge clk); #1;
    end
    out_ready_a = 1'b1;
    beat_a("bp b2", 8'hAA, 8'h55, 1'b0, 8'hFF, 8'hD9, 16'd2);
    beat_a("bp b3", 8'h01, 8'h01, 1'b1, 8'h00, 8'hD9, 16'd3);
    idle_a();

    // Reset mid-frame, with a beat offered during reset: reset wins.
    beat_a("rs b1", 8'h12, 8'h34, 1'b0, 8'h26, 8'h26, 16'd1);
    beat_a("rs b2", 8'hAA, 8'h55, 1'b0, 8'hFF, 8'hD9, 16'd2);
    rst = 1'b1;
    in_data_a = {8'h77, 8'h11};
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid_a = 1'b0;
    check_eq("rs valid", 32'(out_valid_a), 32'd0);
    check_eq("rs chk",   32'(out_chk_a),   32'd0);
    beat_a("rs new", 8'h0F, 8'h00, 1'b1, 8'h0F, 8'h0F, 16'd1);
    idle_a();

    // Four channels, 2-bit counter, 5-beat frame.
    in_data_b  = {8'h08, 8'h04, 8'h02, 8'h01};
    in_valid_b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_last_b = (i == 4);
      #1;
      check_eq("ch4 in_ready", 32'(in_ready_b), 32'd1);
      @(posedge clk); #1;
      check_eq("ch4 data", 32'(out_data_b), 32'h0F);
      check_eq("ch4 chk",  32'(out_chk_b),  32'(exp_chk_b[i]));
      check_eq("ch4 last", 32'(out_last_b), (i == 4) ? 32'd1 : 32'd0);
`ifdef XOR_CHK_COUNT_EN
      check_eq("ch4 beats", 32'(out_beats_b), 32'(exp_beats_b[i]));
`endif
    end
    in_valid_b = 1'b0;
    in_last_b  = 1'b0;

    // Single channel passes through.
    in_data_c  = 8'hA5;
    in_last_c  = 1'b1;
    in_valid_c = 1'b1;
    @(posedge clk); #1;
    in_valid_c = 1'b0;
    check_eq("ch1 valid", 32'(out_valid_c), 32'd1);
    check_eq("ch1 data",  32'(out_data_c),  32'hA5);
    check_eq("ch1 chk",   32'(out_chk_c),   32'hA5);
    check_eq("ch1 last",  32'(out_last_c),  32'd1);
`ifdef XOR_CHK_COUNT_EN
    check_eq("ch1 beats", 32'(out_beats_c), 32'd1);
`endif
    check_eq("ch1 in_ready", 32'(in_ready_c), 32'd1);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
